button_event_reader: RTL and testbench
======================================

BUTTON_EVENT_READER -- requirements
Module: button_event_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 270000, consecutive stable synchronized samples needed to qualify a press or release (10 ms at 27 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter LONG_CYCLES, default 27000000, number of cycles held after the qualified press before long_press fires (1 s at 27 MHz); legal range 2..2^25-1.
REQ-003 SHALL have port sys_clk, input, 1, the only clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port btn_n, input, 1, raw asynchronous pushbutton, active-low (0 = pressed), may bounce.
REQ-006 SHALL have port btn_level, output, 1, debounced state, 1 = pressed.
REQ-007 SHALL have port press_pulse, output, 1, one-cycle strobe on a qualified press.
REQ-008 SHALL have port release_pulse, output, 1, one-cycle strobe on a qualified release.
REQ-009 SHALL have port short_click, output, 1, one-cycle strobe coincident with release_pulse when the hold did not reach long_press.
REQ-010 SHALL have port long_press, output, 1, one-cycle strobe when the hold reaches LONG_CYCLES.
REQ-011 SHALL have port press_count, output, 8, count of qualified presses, modulo 256.

Function
REQ-012 SHALL pass btn_n through a 2-flop synchronizer (btn_s) before any other use; no other logic samples btn_n.
REQ-013 SHALL implement FSM states IDLE, PRESS_WAIT, PRESSED, LONG_HELD, RELEASE_WAIT.
REQ-014 IDLE: btn_s=0 -> PRESS_WAIT, debounce counter counts this sample as 1.
REQ-015 PRESS_WAIT: btn_s=1 on any edge -> IDLE, counter cleared, no output strobes (bounce rejected).
REQ-016 PRESS_WAIT: on the edge taking the DEBOUNCE_CYCLES-th consecutive low sample -> PRESSED; the same edge registers press_pulse=1, btn_level=1, press_count+1, and clears the hold counter.
REQ-017 Press latency: taking edge 0 as the first edge at which btn_n=0 is sampled, press_pulse SHALL be high in the cycle after edge DEBOUNCE_CYCLES+1.
REQ-018 PRESSED: the hold counter increments every cycle; after the edge at which it reaches LONG_CYCLES -> LONG_HELD, with long_press=1 for exactly that cycle (LONG_CYCLES cycles after the press_pulse cycle).
REQ-019 PRESSED or LONG_HELD: btn_s=1 -> RELEASE_WAIT; the block records the originating state, freezes the hold counter, and sets the debounce counter to 1.
REQ-020 RELEASE_WAIT: btn_s=0 before qualification -> return to the recorded state; the hold counter resumes from its frozen value and no strobes are issued.
REQ-021 RELEASE_WAIT: on the edge taking the DEBOUNCE_CYCLES-th consecutive high sample -> IDLE; the same edge registers release_pulse=1 and btn_level=0, plus short_click=1 if the recorded state was PRESSED.
REQ-022 All strobes SHALL be registered and high for exactly one cycle; long_press SHALL fire at most once per press.
REQ-023 press_count SHALL wrap 255 -> 0 with no other side effects.
REQ-024 Counters SHALL saturate-proof: the debounce counter never exceeds DEBOUNCE_CYCLES, and the hold counter stops at LONG_CYCLES in LONG_HELD.
REQ-025 A held button SHALL never retrigger press_pulse; a new press requires passing through IDLE.

Reset
REQ-026 sys_rst=1 SHALL asynchronously force: both synchronizer flops=1 (released), state=IDLE, all counters=0, btn_level=0, all strobes=0, press_count=0.
REQ-027 Reset asserted mid-press or mid-hold SHALL abort without any strobe; after deassertion a still-held button SHALL be requalified as a fresh press (full DEBOUNCE_CYCLES).
REQ-028 Release of reset SHALL be used synchronously by the bench; the block requires no minimum reset width beyond one sys_clk period.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Clean press: btn_n low from edge 0 -> press_pulse=1 only in the cycle after edge 5, btn_level=1, press_count=1.
REQ-030 Bounce: btn_n low for 3 cycles, high for 1, then low steady -> no strobe from the first burst; a single press_pulse 4 qualifying samples after the final fall.
REQ-031 Short click: hold for 10 cycles after press_pulse, then release cleanly -> release_pulse and short_click in the same cycle, long_press never asserted.
REQ-032 Long hold: hold for 30 cycles -> long_press exactly 20 cycles after press_pulse; on release, release_pulse=1 and short_click=0.
REQ-033 Release bounce plus reset: during RELEASE_WAIT, btn_n low for 2 cycles -> return to the prior state with no strobes; assert sys_rst while held -> all outputs 0 immediately; deassert with button held -> new press_pulse after 4 qualifying samples, press_count=1.
REQ-034 Wrap: 256 qualified presses -> press_count returns to 0 on the 256th press_pulse.

Source files
------------

// File: rtl/button_event_reader.sv
// Debounced pushbutton reader with press/release/short/long event strobes
// and a wrapping press counter; one clock, async active-high reset.
module button_event_reader #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int LONG_CYCLES     = 27000000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       btn_n,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       short_click,
   output logic       long_press,
   output logic [7:0] press_count
);

   localparam logic [2:0] IDLE         = 3'd0;
   localparam logic [2:0] PRESS_WAIT   = 3'd1;
   localparam logic [2:0] PRESSED      = 3'd2;
   localparam logic [2:0] LONG_HELD    = 3'd3;
   localparam logic [2:0] RELEASE_WAIT = 3'd4;

   localparam logic [23:0] DB_LAST   = 24'(DEBOUNCE_CYCLES - 1);
   localparam logic [24:0] HOLD_LAST = 25'(LONG_CYCLES - 1);
   localparam logic [24:0] HOLD_MAX  = 25'(LONG_CYCLES);

   logic [1:0]  sync_q;
   logic        btn_s;
   logic [2:0]  state_q, state_d;
   logic        from_long_q, from_long_d;
   logic [23:0] deb_q, deb_d;
   logic [24:0] hold_q, hold_d;
   logic        level_q, level_d;
   logic        press_q, press_d;
   logic        rel_q, rel_d;
   logic        short_q, short_d;
   logic        long_q, long_d;
   logic [7:0]  count_q, count_d;

   // btn_n is active-low, so the synchronizer idles at 1 (released)
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) sync_q <= 2'b11;
      else         sync_q <= {sync_q[0], btn_n};
   end

   assign btn_s = sync_q[1];

   always_comb begin
      state_d     = state_q;
      from_long_d = from_long_q;
      deb_d       = deb_q;
      hold_d      = hold_q;
      level_d     = level_q;
      count_d     = count_q;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      short_d     = 1'b0;
      long_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!btn_s) begin
               state_d = PRESS_WAIT;
               deb_d   = 24'd1;
            end
         end
         PRESS_WAIT: begin
            if (btn_s) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DB_LAST) begin
               state_d = PRESSED;
               deb_d   = '0;
               hold_d  = '0;
               press_d = 1'b1;
               level_d = 1'b1;
               count_d = count_q + 8'd1;
            end else begin
               deb_d = deb_q + 24'd1;
            end
         end
         PRESSED: begin
            if (btn_s) begin
               state_d     = RELEASE_WAIT;
               from_long_d = 1'b0;
               deb_d       = 24'd1;
            end else if (hold_q == HOLD_LAST) begin
               state_d = LONG_HELD;
               hold_d  = HOLD_MAX;
               long_d  = 1'b1;
            end else begin
               hold_d = hold_q + 25'd1;
            end
         end
         LONG_HELD: begin
            if (btn_s) begin
               state_d     = RELEASE_WAIT;
               from_long_d = 1'b1;
               deb_d       = 24'd1;
            end
         end
         RELEASE_WAIT: begin
            // hold_q stays frozen here so a bounced release resumes timing
            if (!btn_s) begin
               state_d = from_long_q ? LONG_HELD : PRESSED;
               deb_d   = '0;
            end else if (deb_q == DB_LAST) begin
               state_d = IDLE;
               deb_d   = '0;
               rel_d   = 1'b1;
               short_d = !from_long_q;
               level_d = 1'b0;
            end else begin
               deb_d = deb_q + 24'd1;
            end
         end
         default: begin
            state_d = IDLE;
            deb_d   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= IDLE;
         from_long_q <= 1'b0;
         deb_q       <= '0;
         hold_q      <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         rel_q       <= 1'b0;
         short_q     <= 1'b0;
         long_q      <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         from_long_q <= from_long_d;
         deb_q       <= deb_d;
         hold_q      <= hold_d;
         level_q     <= level_d;
         press_q     <= press_d;
         rel_q       <= rel_d;
         short_q     <= short_d;
         long_q      <= long_d;
         count_q     <= count_d;
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign short_click   = short_q;
   assign long_press    = long_q;
   assign press_count   = count_q;

endmodule

// File: tb/tb_button_event_reader.sv
// Bench for button_event_reader: directed scenarios plus random bursts,
// all outputs compared every cycle against a run-length reference model.
module tb_button_event_reader;

   localparam int DB = 4;
   localparam int LC = 20;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       btn_n   = 1'b1;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_click;
   logic       long_press;
   logic [7:0] press_count;

   button_event_reader #(
      .DEBOUNCE_CYCLES(DB),
      .LONG_CYCLES    (LC)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .btn_n        (btn_n),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .short_click  (short_click),
      .long_press   (long_press),
      .press_count  (press_count)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // reference model: sync pipe, run length of the current sample level
   logic m_s1, m_s2;
   int   m_run, m_hold, m_count;
   bit   m_pressed, m_long_done;
   bit   m_press, m_rel, m_short, m_long;

   int last_press, last_long, last_rel, last_short;
   int n_press, n_long, n_short, n_rel;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0d want %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b1;
      m_s2 = 1'b1;
      m_run = 0;
      m_hold = 0;
      m_count = 0;
      m_pressed = 0;
      m_long_done = 0;
      m_press = 0;
      m_rel = 0;
      m_short = 0;
      m_long = 0;
   endtask

   task automatic model_edge();
      logic s;
      s = m_s2;
      m_s2 = m_s1;
      m_s1 = btn_n;
      m_press = 0;
      m_rel = 0;
      m_short = 0;
      m_long = 0;
      if (!m_pressed) begin
         m_run = (s == 1'b0) ? m_run + 1 : 0;
         if (m_run == DB) begin
            m_pressed = 1;
            m_press = 1;
            m_count = (m_count + 1) % 256;
            m_hold = 0;
            m_run = 0;
            m_long_done = 0;
         end
      end else if (s == 1'b1) begin
         m_run++;
         if (m_run == DB) begin
            m_pressed = 0;
            m_rel = 1;
            m_short = !m_long_done;
            m_run = 0;
         end
      end else begin
         // a low sample ending a release bounce does not advance the hold
         if (m_run == 0 && !m_long_done) begin
            m_hold++;
            if (m_hold == LC) begin
               m_long = 1;
               m_long_done = 1;
            end
         end
         m_run = 0;
      end
   endtask

   task automatic cycle(input logic b);
      btn_n = b;
      @(posedge sys_clk);
      cyc++;
      model_edge();
      @(negedge sys_clk);
      check("btn_level", int'(btn_level), int'(m_pressed));
      check("press_pulse", int'(press_pulse), int'(m_press));
      check("release_pulse", int'(release_pulse), int'(m_rel));
      check("short_click", int'(short_click), int'(m_short));
      check("long_press", int'(long_press), int'(m_long));
      check("press_count", int'(press_count), m_count);
      if (press_pulse) begin last_press = cyc; n_press++; end
      if (long_press) begin last_long = cyc; n_long++; end
      if (release_pulse) begin last_rel = cyc; n_rel++; end
      if (short_click) begin last_short = cyc; n_short++; end
   endtask

   task automatic do_reset();
      @(negedge sys_clk);
      sys_rst = 1'b1;
      model_reset();
      #1;
      check("rst_level", int'(btn_level), 0);
      check("rst_press", int'(press_pulse), 0);
      check("rst_release", int'(release_pulse), 0);
      check("rst_short", int'(short_click), 0);
      check("rst_long", int'(long_press), 0);
      check("rst_count", int'(press_count), 0);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic clear_stats();
      n_press = 0;
      n_long = 0;
      n_short = 0;
      n_rel = 0;
   endtask

   initial begin
      int e0;
      int ff;
      model_reset();
      do_reset();

      // clean press then short click
      clear_stats();
      e0 = cyc + 1;
      repeat (16) cycle(1'b0);
      check("press_lat", last_press - e0, DB + 1);
      check("press_cnt1", int'(press_count), 1);
      repeat (10) cycle(1'b1);
      check("short_n", n_short, 1);
      check("short_with_rel", last_short, last_rel);
      check("short_no_long", n_long, 0);

      // long hold
      clear_stats();
      repeat (35) cycle(1'b0);
      check("long_n", n_long, 1);
      check("long_lat", last_long - last_press, LC);
      repeat (10) cycle(1'b1);
      check("long_rel_n", n_rel, 1);
      check("long_no_short", n_short, 0);

      // press bounce
      clear_stats();
      repeat (3) cycle(1'b0);
      cycle(1'b1);
      ff = cyc + 1;
      repeat (12) cycle(1'b0);
      check("bounce_n", n_press, 1);
      check("bounce_lat", last_press - ff, DB + 1);

      // release bounce, then reset while held
      clear_stats();
      repeat (2) cycle(1'b1);
      repeat (2) cycle(1'b0);
      repeat (6) cycle(1'b0);
      check("relb_rel", n_rel, 0);
      check("relb_level", int'(btn_level), 1);
      btn_n = 1'b0;
      do_reset();
      clear_stats();
      e0 = cyc + 1;
      repeat (10) cycle(1'b0);
      check("rst_repress_lat", last_press - e0, DB + 1);
      check("rst_repress_cnt", int'(press_count), 1);
      repeat (8) cycle(1'b1);

      // randomized bursts with occasional resets
      for (int k = 0; k < 150; k++) begin
         int  len;
         logic lvl;
         lvl = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ?
               int'($urandom_range(1, 40)) : int'($urandom_range(1, 8));
         repeat (len) cycle(lvl);
         if ($urandom_range(0, 30) == 0) do_reset();
      end

      // wrap of press_count
      btn_n = 1'b1;
      do_reset();
      for (int i = 0; i < 256; i++) begin
         repeat (7) cycle(1'b0);
         if (i == 254) check("count_255", int'(press_count), 255);
         repeat (7) cycle(1'b1);
      end
      check("wrap_count", int'(press_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
